vga_layer_compositor: RTL and testbench
=======================================

Name: vga_layer_compositor

Overview:
- Parametrised successor to the fixed 640x480 graphics block.
- Generates VGA timing from configurable porch and sync parameters and composites NUM_LAYERS rectangular sprite layers over a background colour.
- Priority: lowest layer index wins.
- Layer geometry is double-buffered and latched only at frame boundaries, so there is no tearing; RGB332 output is pipelined and aligned to the sync outputs.
- Sits between the game logic (ball/paddle positions) and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of HS/VS
- NUM_LAYERS, 4, number of sprite layers (1..8)
- CW, 10, coordinate width

Ports:
- clk25M  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-low reset
- layer_en  in  NUM_LAYERS  per-layer enable
- layer_x  in  NUM_LAYERS*CW  left edge; layer i occupies bits [i*CW +: CW]
- layer_y  in  NUM_LAYERS*CW  top edge
- layer_w  in  NUM_LAYERS*CW  width in pixels
- layer_h  in  NUM_LAYERS*CW  height in lines
- layer_rgb  in  NUM_LAYERS*8  colour {r[2:0],g[2:0],b[1:0]}
- bg_rgb  in  8  background colour, sampled live (not shadowed)
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- endofframe  out  1  one-cycle pulse at start of vertical blanking
- frame_count  out  16  completed-frame counter, wraps
- pixel_x  out  CW  current active-area x (stage-0, unaligned, for debug)

Behaviour:
Counters
- H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- hcount runs 0..H_TOTAL-1.
- vcount increments when hcount == H_TOTAL-1 and wraps after V_TOTAL-1.

Stage 0 decode
- Sync is active when hcount < H_SYNC (HS) or vcount < V_SYNC (VS).
- Active region: H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE, and the same form vertically.
- x = hcount-(H_SYNC+H_BP); y = vcount-(V_SYNC+V_BP).

Shadow registers
- All layer_* inputs are copied into shadow registers on the cycle where hcount == H_TOTAL-1 and vcount == V_TOTAL-1.
- Layers render only from the shadows; input changes mid-frame are invisible until the next frame.

Hit test (stage 1, registered)
- Layer i hits when: en, and x >= lx, and x < lx+lw, and y >= ly, and y < ly+lh.
- Sums are computed at CW+1 bits, so there is no wrap; a layer extending past the screen edge is clipped.
- w == 0 or h == 0 never hits.

Colour select (stage 2, registered)
- Outside the active area: colour is 0.
- Otherwise: colour of the lowest-index hitting layer, else bg_rgb.

Latency and alignment
- red/green/blue, HS and VS all appear 2 cycles after the counter state that produced them.
- Sync is delayed through matching registers, so alignment is exact.

endofframe
- Registered pulse, high exactly one cycle, aligned with the output pipeline.
- Produced for the counter state hcount == 0, vcount == V_SYNC+V_BP+V_ACTIVE.

frame_count
- Increments on the same counter state as endofframe; wraps 0xFFFF -> 0.

Reset (reset == 0 at a clock edge)
- hcount and vcount go to 0.
- All pipeline regs and RGB outputs go to 0; HS/VS go to the inactive level (~SYNC_POL).
- Shadows go to 0 (no layers visible); frame_count = 0; endofframe = 0.
- Reset asserted mid-frame aborts the frame.
- The first cycle after release is counter state (0,0); no endofframe fires for the aborted frame.

Overlap
- Overlapping layers: strict index priority, no blending.

Decomposition:
- Shared package/include vga_defs: default 640x480 timing constants, RGB332 field macros, and a black constant.
- One natural sub-module, vga_timing_gen: counters, sync decode, active flag, x/y and the frame-start strobe. Reusable by other display blocks.
- The compositor instantiates vga_timing_gen and holds the shadows, hit pipeline and priority mux.

Test Plan:
- Reset release, defaults: HS low for 96 of every 800 cycles; VS low for 2 of every 525 lines; red/green/blue = 0 outside the active area.
- All layers disabled, bg_rgb = 8'h25: every active pixel outputs r=1, g=1, b=1; first visible pixel appears 2 cycles after hcount = 144.
- Layers 0 and 1 overlap:
  - Layer 0 at (100,100) 10x10, rgb = 8'hE0.
  - Layer 1 at (105,105) 10x10, rgb = 8'h1C.
  - Pixel (107,107) = 8'hE0; (112,112) = 8'h1C; (110,100) = bg.
- Edge clipping: layer at x = 635, w = 20: pixels 635..639 are coloured; no wrap to x = 0..14.
- w = 0 layer: no pixels are coloured.
- Tear test: change layer_x from 50 to 300 at line 200 of frame N.
  - Frame N still shows x = 50 on all lines.
  - Frame N+1 shows x = 300.
  - endofframe pulses once per frame; frame_count goes 0 -> 1 -> 2.
- Reset at line 300 for 3 cycles: outputs black and syncs inactive during reset; counters restart at (0,0); frame_count = 0; no spurious endofframe.

Source files
------------

// File: rtl/vga_layer_compositor_pkg.sv
// Shared VGA definitions: default 640x480 timing, RGB332 field helpers
// and the inter-stage bundle used by the compositor pipeline.
package vga_layer_compositor_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int RGB_W = 8;
  localparam logic [RGB_W-1:0] BLACK = 8'h00;

  function automatic logic [2:0] rgb_r(input logic [7:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb_g(input logic [7:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb_b(input logic [7:0] c);
    return c[1:0];
  endfunction

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic eof;
  } stage1_t;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters with stage-0 decode: sync, active window,
// active-area x/y, vblank-start and last-pixel-of-frame strobes.
module vga_timing_gen
  import vga_layer_compositor_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          vblank_start,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_STOP  = H_START + H_ACTIVE;
  localparam int V_STOP  = V_START + V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_end;
  logic          v_end;
  logic          h_act;
  logic          v_act;

  assign h_end = (hcount == HW'(H_TOTAL - 1));
  assign v_end = (vcount == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + HW'(1);
      if (h_end)
        vcount <= v_end ? '0 : vcount + VW'(1);
    end
  end

  assign h_act = (hcount >= HW'(H_START)) && (hcount < HW'(H_STOP));
  assign v_act = (vcount >= VW'(V_START)) && (vcount < VW'(V_STOP));

  assign hs     = (hcount < HW'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign vs     = (vcount < VW'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign active = h_act && v_act;
  assign x      = CW'(hcount - HW'(H_START));
  assign y      = CW'(vcount - VW'(V_START));

  assign vblank_start = (hcount == '0) && (vcount == VW'(V_STOP));
  assign frame_end    = h_end && v_end;

endmodule

// File: rtl/vga_layer_compositor.sv
// Composites NUM_LAYERS frame-latched rectangles over a live background
// and drives RGB332 plus sync, all aligned two cycles after the counters.
module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int NUM_LAYERS = 4,
  parameter int CW         = 10
) (
  input  logic                       clk25M,
  input  logic                       reset,
  input  logic [NUM_LAYERS-1:0]      layer_en,
  input  logic [NUM_LAYERS*CW-1:0]   layer_x,
  input  logic [NUM_LAYERS*CW-1:0]   layer_y,
  input  logic [NUM_LAYERS*CW-1:0]   layer_w,
  input  logic [NUM_LAYERS*CW-1:0]   layer_h,
  input  logic [NUM_LAYERS*8-1:0]    layer_rgb,
  input  logic [7:0]                 bg_rgb,
  output logic [2:0]                 red,
  output logic [2:0]                 green,
  output logic [1:0]                 blue,
  output logic                       HS,
  output logic                       VS,
  output logic                       endofframe,
  output logic [15:0]                frame_count,
  output logic [CW-1:0]              pixel_x
);

  logic          hs0;
  logic          vs0;
  logic          act0;
  logic [CW-1:0] x0;
  logic [CW-1:0] y0;
  logic          vbs0;
  logic          fend0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .CW       (CW)
  ) u_timing (
    .clk          (clk25M),
    .reset        (reset),
    .hs           (hs0),
    .vs           (vs0),
    .active       (act0),
    .x            (x0),
    .y            (y0),
    .vblank_start (vbs0),
    .frame_end    (fend0)
  );

  logic [NUM_LAYERS-1:0]    sh_en;
  logic [NUM_LAYERS*CW-1:0] sh_x;
  logic [NUM_LAYERS*CW-1:0] sh_y;
  logic [NUM_LAYERS*CW-1:0] sh_w;
  logic [NUM_LAYERS*CW-1:0] sh_h;
  logic [NUM_LAYERS*8-1:0]  sh_rgb;

  // Geometry swaps only on the last pixel of a frame, so no tearing.
  always_ff @(posedge clk25M) begin
    if (!reset) begin
      sh_en  <= '0;
      sh_x   <= '0;
      sh_y   <= '0;
      sh_w   <= '0;
      sh_h   <= '0;
      sh_rgb <= '0;
    end else if (fend0) begin
      sh_en  <= layer_en;
      sh_x   <= layer_x;
      sh_y   <= layer_y;
      sh_w   <= layer_w;
      sh_h   <= layer_h;
      sh_rgb <= layer_rgb;
    end
  end

  logic [NUM_LAYERS-1:0] hit;

  // CW+1 bit sums keep right/bottom edges past the screen from wrapping.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      hit[i] = sh_en[i]
        && ({1'b0, x0} >= {1'b0, sh_x[i*CW +: CW]})
        && ({1'b0, x0} <  {1'b0, sh_x[i*CW +: CW]}
                        + {1'b0, sh_w[i*CW +: CW]})
        && ({1'b0, y0} >= {1'b0, sh_y[i*CW +: CW]})
        && ({1'b0, y0} <  {1'b0, sh_y[i*CW +: CW]}
                        + {1'b0, sh_h[i*CW +: CW]});
    end
  end

  stage1_t               s1;
  logic [NUM_LAYERS-1:0] hit1;

  always_ff @(posedge clk25M) begin
    if (!reset) begin
      s1   <= '{active: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, eof: 1'b0};
      hit1 <= '0;
    end else begin
      s1   <= '{active: act0, hs: hs0, vs: vs0, eof: vbs0};
      hit1 <= hit;
    end
  end

  logic [7:0] colour;

  // Walk from the top index down so the lowest hitting index wins.
  always_comb begin
    colour = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit1[i])
        colour = sh_rgb[i*8 +: 8];
    end
    if (!s1.active)
      colour = BLACK;
  end

  always_ff @(posedge clk25M) begin
    if (!reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      HS          <= ~SYNC_POL;
      VS          <= ~SYNC_POL;
      endofframe  <= 1'b0;
      frame_count <= '0;
    end else begin
      red         <= rgb_r(colour);
      green       <= rgb_g(colour);
      blue        <= rgb_b(colour);
      HS          <= s1.hs;
      VS          <= s1.vs;
      endofframe  <= s1.eof;
      frame_count <= frame_count + {15'd0, s1.eof};
    end
  end

  assign pixel_x = x0;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor on a reduced raster: a cycle model feeds
// a two-deep scoreboard, and scenario tasks inspect captured frames.
module tb_vga_layer_compositor;

  localparam int HA  = 48;
  localparam int HF  = 2;
  localparam int HSY = 4;
  localparam int HB  = 3;
  localparam int VA  = 36;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 2;
  localparam int NL  = 4;
  localparam int CW  = 10;
  localparam bit POL = 1'b0;
  localparam logic IDLE = ~POL;
  localparam int HT   = HA + HF + HSY + HB;
  localparam int VT   = VA + VF + VSY + VB;
  localparam int VEOF = VSY + VB + VA;
  localparam logic [7:0] BG = 8'h25;

  logic              clk25M = 1'b0;
  logic              reset = 1'b0;
  logic [NL-1:0]     layer_en = '0;
  logic [NL*CW-1:0]  layer_x = '0;
  logic [NL*CW-1:0]  layer_y = '0;
  logic [NL*CW-1:0]  layer_w = '0;
  logic [NL*CW-1:0]  layer_h = '0;
  logic [NL*8-1:0]   layer_rgb = '0;
  logic [7:0]        bg_rgb = BG;
  logic [2:0]        red;
  logic [2:0]        green;
  logic [1:0]        blue;
  logic              HS;
  logic              VS;
  logic              endofframe;
  logic [15:0]       frame_count;
  logic [CW-1:0]     pixel_x;

  vga_layer_compositor #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .SYNC_POL (POL), .NUM_LAYERS (NL), .CW (CW)
  ) dut (
    .clk25M      (clk25M),
    .reset       (reset),
    .layer_en    (layer_en),
    .layer_x     (layer_x),
    .layer_y     (layer_y),
    .layer_w     (layer_w),
    .layer_h     (layer_h),
    .layer_rgb   (layer_rgb),
    .bg_rgb      (bg_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .HS          (HS),
    .VS          (VS),
    .endofframe  (endofframe),
    .frame_count (frame_count),
    .pixel_x     (pixel_x)
  );

  always #20 clk25M = ~clk25M;

  typedef struct {
    int         h;
    int         v;
    bit         active;
    int         x;
    int         y;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       eof;
  } exp_t;

  exp_t       q[$];
  int         mh = 0;
  int         mv = 0;
  int         m_fc = 0;
  bit         s_en[NL];
  int         s_x[NL];
  int         s_y[NL];
  int         s_w[NL];
  int         s_h[NL];
  logic [7:0] s_rgb[NL];
  int         vectors = 0;
  int         errors = 0;
  int         eof_seen = 0;
  logic [7:0] cap [0:VA-1][0:HA-1];

  function automatic exp_t reset_entry();
    exp_t e;
    e.h = -1; e.v = -1; e.active = 0; e.x = 0; e.y = 0;
    e.rgb = 8'h00; e.hs = IDLE; e.vs = IDLE; e.eof = 1'b0;
    return e;
  endfunction

  function automatic exp_t expect_at(int h, int v);
    exp_t e;
    bit found;
    e.h = h;
    e.v = v;
    e.hs = (h < HSY) ? POL : IDLE;
    e.vs = (v < VSY) ? POL : IDLE;
    e.x = h - (HSY + HB);
    e.y = v - (VSY + VB);
    e.active = (e.x >= 0) && (e.x < HA) && (e.y >= 0) && (e.y < VA);
    e.eof = (h == 0) && (v == VEOF);
    e.rgb = 8'h00;
    if (e.active) begin
      e.rgb = bg_rgb;
      found = 0;
      for (int i = 0; i < NL; i++) begin
        if (!found && s_en[i]
            && e.x >= s_x[i] && e.x < s_x[i] + s_w[i]
            && e.y >= s_y[i] && e.y < s_y[i] + s_h[i]) begin
          e.rgb = s_rgb[i];
          found = 1;
        end
      end
    end
    return e;
  endfunction

  // Raster and shadow model, advanced on the same edge as the DUT.
  always @(posedge clk25M) begin
    if (!reset) begin
      mh = 0;
      mv = 0;
      m_fc = 0;
      for (int i = 0; i < NL; i++) begin
        s_en[i] = 0; s_x[i] = 0; s_y[i] = 0;
        s_w[i] = 0; s_h[i] = 0; s_rgb[i] = 8'h00;
      end
      q.delete();
      q.push_back(reset_entry());
      q.push_back(reset_entry());
    end else begin
      if (mh == HT - 1 && mv == VT - 1) begin
        for (int i = 0; i < NL; i++) begin
          s_en[i]  = layer_en[i];
          s_x[i]   = int'(layer_x[i*CW +: CW]);
          s_y[i]   = int'(layer_y[i*CW +: CW]);
          s_w[i]   = int'(layer_w[i*CW +: CW]);
          s_h[i]   = int'(layer_h[i*CW +: CW]);
          s_rgb[i] = layer_rgb[i*8 +: 8];
        end
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // Scoreboard: expectation pushed per counter state, popped two cycles on.
  always @(negedge clk25M) begin
    exp_t e;
    logic [7:0] got;
    q.push_back(expect_at(mh, mv));
    if (q.size() > 2) begin
      e = q.pop_front();
      if (e.eof) m_fc = (m_fc + 1) & 16'hFFFF;
      got = {red, green, blue};
      vectors++;
      if ({got, HS, VS, endofframe, frame_count}
          !== {e.rgb, e.hs, e.vs, e.eof, 16'(m_fc)}) begin
        errors++;
        $display("FAIL scoreboard h=%0d v=%0d got rgb=%h hs=%b vs=%b eof=%b fc=%0d want rgb=%h hs=%b vs=%b eof=%b fc=%0d",
                 e.h, e.v, got, HS, VS, endofframe, frame_count,
                 e.rgb, e.hs, e.vs, e.eof, m_fc);
      end
      if (e.active) cap[e.y][e.x] = got;
    end
    if (endofframe === 1'b1) eof_seen++;
  end

  task automatic set_layer(input int i, input bit en, input int x,
                           input int y, input int w, input int h,
                           input logic [7:0] rgb);
    layer_en[i] = en;
    layer_x[i*CW +: CW] = x[CW-1:0];
    layer_y[i*CW +: CW] = y[CW-1:0];
    layer_w[i*CW +: CW] = w[CW-1:0];
    layer_h[i*CW +: CW] = h[CW-1:0];
    layer_rgb[i*8 +: 8] = rgb;
  endtask

  task automatic clear_layers();
    layer_en = '0; layer_x = '0; layer_y = '0;
    layer_w = '0; layer_h = '0; layer_rgb = '0;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk25M);
    reset = 1'b0;
    repeat (n) @(negedge clk25M);
    reset = 1'b1;
  endtask

  task automatic wait_state(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk25M);
      n++;
    end while (!(mh == h && mv == v) && n < 3 * HT * VT);
    if (!(mh == h && mv == v)) begin
      errors++;
      $display("FAIL wait_state timeout at (%0d,%0d) want (%0d,%0d)", mh, mv, h, v);
    end
  endtask

  task automatic run_frame();
    wait_state(0, 0);
    wait_state(2, VEOF);
  endtask

  task automatic test_reset();
    clear_layers();
    bg_rgb = BG;
    @(negedge clk25M);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk25M);
      vectors++;
      if ({red, green, blue, HS, VS, endofframe, frame_count}
          !== {8'h00, IDLE, IDLE, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_state got %h%b%b%b fc=%0d want 00%b%b0 fc=0",
                 {red, green, blue}, HS, VS, endofframe, frame_count, IDLE, IDLE);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_sync();
    int hs_n;
    int vs_n;
    hs_n = 0;
    vs_n = 0;
    repeat (HT * VT) begin
      @(negedge clk25M);
      if (HS === POL) hs_n++;
      if (VS === POL) vs_n++;
    end
    vectors++;
    if (hs_n != HSY * VT) begin
      errors++;
      $display("FAIL hs_width got %0d want %0d", hs_n, HSY * VT);
    end
    vectors++;
    if (vs_n != VSY * HT) begin
      errors++;
      $display("FAIL vs_width got %0d want %0d", vs_n, VSY * HT);
    end
  endtask

  task automatic test_background();
    int n;
    int bad;
    clear_layers();
    bg_rgb = BG;
    apply_reset(2);
    n = 0;
    while ({red, green, blue} === 8'h00 && n < 2 * HT * VT) begin
      @(negedge clk25M);
      n++;
    end
    vectors++;
    if (n != (VSY + VB) * HT + HSY + HB + 2) begin
      errors++;
      $display("FAIL first_pixel_latency got %0d want %0d", n, (VSY + VB) * HT + HSY + HB + 2);
    end
    vectors++;
    if ({red, green, blue} !== {3'd1, 3'd1, 2'd1}) begin
      errors++;
      $display("FAIL first_pixel_colour got %h want 25", {red, green, blue});
    end
    wait_state(2, VEOF);
    bad = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (cap[y][x] !== BG) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL background_frame got %0d non-bg pixels want 0", bad);
    end
  endtask

  task automatic test_overlap();
    clear_layers();
    set_layer(0, 1, 10, 10, 6, 6, 8'hE0);
    set_layer(1, 1, 13, 13, 6, 6, 8'h1C);
    run_frame();
    vectors++;
    if (cap[14][14] !== 8'hE0) begin
      errors++;
      $display("FAIL overlap_l0 got %h want e0", cap[14][14]);
    end
    vectors++;
    if (cap[13][13] !== 8'hE0) begin
      errors++;
      $display("FAIL overlap_corner got %h want e0", cap[13][13]);
    end
    vectors++;
    if (cap[17][17] !== 8'h1C) begin
      errors++;
      $display("FAIL overlap_l1 got %h want 1c", cap[17][17]);
    end
    vectors++;
    if (cap[10][16] !== BG) begin
      errors++;
      $display("FAIL overlap_bg got %h want %h", cap[10][16], BG);
    end
    vectors++;
    if (cap[19][19] !== BG) begin
      errors++;
      $display("FAIL overlap_l1_edge got %h want %h", cap[19][19], BG);
    end
  endtask

  task automatic test_clip();
    int bad;
    clear_layers();
    set_layer(2, 1, HA - 5, 5, 20, 4, 8'h03);
    run_frame();
    vectors++;
    if (cap[6][HA-5] !== 8'h03 || cap[6][HA-1] !== 8'h03) begin
      errors++;
      $display("FAIL clip_edge got %h %h want 03 03", cap[6][HA-5], cap[6][HA-1]);
    end
    vectors++;
    if (cap[6][HA-6] !== BG) begin
      errors++;
      $display("FAIL clip_left got %h want %h", cap[6][HA-6], BG);
    end
    bad = 0;
    for (int y = 5; y < 9; y++)
      for (int x = 0; x < 15; x++)
        if (cap[y][x] !== BG) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clip_wrap got %0d wrapped pixels want 0", bad);
    end
  endtask

  task automatic test_zero_size();
    int bad;
    clear_layers();
    set_layer(3, 1, 0, 20, 0, 5, 8'hFF);
    set_layer(1, 1, 20, 0, 5, 0, 8'hFF);
    run_frame();
    bad = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (cap[y][x] === 8'hFF) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_size got %0d coloured pixels want 0", bad);
    end
  endtask

  task automatic test_tear();
    int e0;
    clear_layers();
    set_layer(0, 1, 5, 0, 2, VA, 8'hE0);
    apply_reset(2);
    e0 = eof_seen;
    vectors++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL tear_fc0 got %0d want 0", frame_count);
    end
    wait_state(0, 0);
    vectors++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL tear_fc1 got %0d want 1", frame_count);
    end
    wait_state(0, VSY + VB + 20);
    layer_x[0 +: CW] = 10'd25;
    wait_state(2, VEOF);
    vectors++;
    if (cap[0][5] !== 8'hE0 || cap[30][5] !== 8'hE0 || cap[30][25] !== BG) begin
      errors++;
      $display("FAIL tear_frame_n got %h %h %h want e0 e0 %h",
               cap[0][5], cap[30][5], cap[30][25], BG);
    end
    vectors++;
    if (frame_count !== 16'd2) begin
      errors++;
      $display("FAIL tear_fc2 got %0d want 2", frame_count);
    end
    repeat (2) @(negedge clk25M);
    vectors++;
    if (eof_seen - e0 != 2) begin
      errors++;
      $display("FAIL tear_eof_pulses got %0d want 2", eof_seen - e0);
    end
    run_frame();
    vectors++;
    if (cap[0][25] !== 8'hE0 || cap[30][25] !== 8'hE0 || cap[30][5] !== BG) begin
      errors++;
      $display("FAIL tear_frame_n1 got %h %h %h want e0 e0 %h",
               cap[0][25], cap[30][25], cap[30][5], BG);
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    wait_state(0, VSY + VB + 25);
    @(negedge clk25M);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk25M);
      vectors++;
      if ({red, green, blue, HS, VS, endofframe}
          !== {8'h00, IDLE, IDLE, 1'b0}) begin
        errors++;
        $display("FAIL midreset_outputs got %h%b%b%b want 00%b%b0",
                 {red, green, blue}, HS, VS, endofframe, IDLE, IDLE);
      end
    end
    reset = 1'b1;
    e0 = eof_seen;
    vectors++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_fc got %0d want 0", frame_count);
    end
    wait_state(2, VEOF);
    repeat (2) @(negedge clk25M);
    vectors++;
    if (eof_seen - e0 != 1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_eof got pulses=%0d fc=%0d want 1 1", eof_seen - e0, frame_count);
    end
    vectors++;
    if (cap[30][25] !== BG) begin
      errors++;
      $display("FAIL midreset_shadow got %h want %h", cap[30][25], BG);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_background();
    test_overlap();
    test_clip();
    test_zero_size();
    test_tear();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
